// File: rtl/uartrx_param.sv
// uartrx_param: parametrised UART receiver.
// Sync'd rx, mid-bit sampling, optional parity, 1-2 stop bits.
`timescale 1ns/1ps
module uartrx_param #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, DONE, BRK
    } state_t;

    state_t state, state_n;
    logic rx_m, rx_s, rx_d;
    logic [CW-1:0] cnt;
    logic [3:0] bidx;
    logic [DATA_BITS-1:0] shreg;
    logic perr, ferr, sample;

    // sample strobe: mid-bit during START, end of bit period elsewhere
    always_comb begin
        sample = (state == START) ? (cnt == MID) : (cnt == LAST);
    end

    // two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state logic; disable forces IDLE from anywhere
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (rx_d && !rx_s) state_n = START;
            START: if (sample) state_n = rx_s ? IDLE : DATA;
            DATA:  if (sample && bidx == DLAST)
                       state_n = (PARITY != 0) ? PAR : STOP;
            PAR:   if (sample) state_n = STOP;
            STOP:  if (sample && bidx == SLAST) state_n = DONE;
            DONE:  state_n = rx_s ? IDLE : BRK;
            BRK:   if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (!en) state_n = IDLE;
    end

    // bit-period counter and bit index; both restart on any state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bidx <= '0;
        end else begin
            if (state_n != state || sample || state == IDLE) cnt <= '0;
            else cnt <= cnt + 1'b1;
            if (state_n != state) bidx <= '0;
            else if (sample) bidx <= bidx + 1'b1;
        end
    end

    // frame datapath: LSB-first shift, parity and stop-bit error accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else if (state == START) begin
            perr <= 1'b0;
            ferr <= 1'b0;
        end else if (sample) begin
            if (state == DATA) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (state == PAR)  perr <= ((^shreg) ^ rx_s) != ODD;
            if (state == STOP) ferr <= ferr | ~rx_s;
        end
    end

    // publish on the last stop sample so outputs are stable while valid is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (state == STOP && state_n == DONE) begin
            dout       <= shreg;
            parity_err <= (PARITY != 0) && perr;
            frame_err  <= ferr | ~rx_s;
        end
    end

    assign valid = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_uartrx_param.sv
// tb_uartrx_param: randomized frames vs. a frame-level reference model.
// Five receiver configurations share clk/rst; rx is steered to one at a time.
`timescale 1ns/1ps
module tb_uartrx_param;

    typedef struct packed {
        logic [3:0]  id;
        logic [8:0]  d;
        logic        pe;
        logic        fe;
        logic [31:0] c;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic rx  = 1'b1;
    int sel = 0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int last_d[5];
    ev_t mq[$];
    ev_t exq[$];
    logic [8:0] snap_d;
    logic snap_v, snap_pe, snap_fe, snap_b;

    logic r0, r1, r2, r3, r4;
    logic [7:0] d0, d1, d2, d3;
    logic [6:0] d4;
    logic v0, v1, v2, v3, v4;
    logic pe0, pe1, pe2, pe3, pe4;
    logic fe0, fe1, fe2, fe3, fe4;
    logic b0, b1, b2, b3, b4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign r0 = (sel == 0) ? rx : 1'b1;
    assign r1 = (sel == 1) ? rx : 1'b1;
    assign r2 = (sel == 2) ? rx : 1'b1;
    assign r3 = (sel == 3) ? rx : 1'b1;
    assign r4 = (sel == 4) ? rx : 1'b1;

    uartrx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .rx(r0), .dout(d0), .valid(v0),
        .parity_err(pe0), .frame_err(fe0), .busy(b0));
    uartrx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .rx(r1), .dout(d1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1));
    uartrx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .rx(r2), .dout(d2), .valid(v2),
        .parity_err(pe2), .frame_err(fe2), .busy(b2));
    uartrx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .en(en), .rx(r3), .dout(d3), .valid(v3),
        .parity_err(pe3), .frame_err(fe3), .busy(b3));
    uartrx_param #(.CLKS_PER_BIT(1041), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u4 (
        .clk(clk), .rst(rst), .en(en), .rx(r4), .dout(d4), .valid(v4),
        .parity_err(pe4), .frame_err(fe4), .busy(b4));

    function automatic ev_t mk(input int id, input logic [8:0] d,
                               input logic pe, input logic fe);
        ev_t m;
        m.id = 4'(id);
        m.d  = d;
        m.pe = pe;
        m.fe = fe;
        m.c  = 32'(cyc);
        return m;
    endfunction

    // log every valid strobe seen on any receiver
    always @(negedge clk) begin
        if (v0 === 1'b1) mq.push_back(mk(0, 9'(d0), pe0, fe0));
        if (v1 === 1'b1) mq.push_back(mk(1, 9'(d1), pe1, fe1));
        if (v2 === 1'b1) mq.push_back(mk(2, 9'(d2), pe2, fe2));
        if (v3 === 1'b1) mq.push_back(mk(3, 9'(d3), pe3, fe3));
        if (v4 === 1'b1) mq.push_back(mk(4, 9'(d4), pe4, fe4));
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; cut_kind 1 drops en, 2 raises rst, before data bit cut_bit.
    // Uncut frames push the expected result: word, parity/stop errors, strobe cycle.
    task automatic send(input int id, input int cpb, input int nb, input int pm,
                        input logic [8:0] data, input logic pbit, input int ns,
                        input logic [1:0] sv, input int cut_bit, input int cut_kind);
        logic seq[16];
        int n;
        int c0;
        int ones;
        logic [8:0] dm;
        ev_t e;
        seq[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nb; i++) begin
            seq[n] = data[i];
            n++;
        end
        if (pm != 0) begin
            seq[n] = pbit;
            n++;
        end
        for (int j = 0; j < ns; j++) begin
            seq[n] = sv[j];
            n++;
        end
        sel = id;
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            if (cut_kind != 0 && k == cut_bit + 1) begin
                if (cut_kind == 1) begin
                    en = 1'b0;
                end else begin
                    rst = 1'b1;
                    #1;
                    snap_d  = 9'(d0);
                    snap_v  = v0;
                    snap_pe = pe0;
                    snap_fe = fe0;
                    snap_b  = b0;
                end
            end
            rx = seq[k];
            repeat (cpb) @(negedge clk);
        end
        if (cut_kind == 0) begin
            dm = data & 9'((1 << nb) - 1);
            ones = $countones(dm) + int'(pbit);
            e.id = 4'(id);
            e.d  = dm;
            e.pe = (pm != 0) && (((ones % 2) == 1) != (pm == 1));
            e.fe = 1'b0;
            for (int j = 0; j < ns; j++) if (!sv[j]) e.fe = 1'b1;
            e.c  = 32'(c0 + 3 + cpb / 2 + (n - 1) * cpb);
            exq.push_back(e);
            last_d[id] = int'(dm);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (d0 !== 8'h00) begin
            fails++;
            $display("FAIL rst_dout: got %0h want 0", d0);
        end
        tests++;
        if (v0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid: got %0b want 0", v0);
        end
        tests++;
        if ({pe0, fe0} !== 2'b00) begin
            fails++;
            $display("FAIL rst_flags: got %0b want 00", {pe0, fe0});
        end
        tests++;
        if (b0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_busy: got %0b want 0", b0);
        end
        tests++;
        if ({d4, v4, b4, b3, b1, pe1} !== 12'h000) begin
            fails++;
            $display("FAIL rst_others: got %0h want 0", {d4, v4, b4, b3, b1, pe1});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) last_d[i] = 0;
        idle(5);
    endtask

    task automatic test_back_to_back();
        idle(4);
        send(0, 16, 8, 0, 9'h045, 1'b0, 1, 2'b11, -1, 0);
        send(0, 16, 8, 0, 9'h0D6, 1'b0, 1, 2'b11, -1, 0);
        for (int i = 0; i < 6; i++)
            send(0, 16, 8, 0, 9'($urandom_range(0, 255)), 1'b0, 1, 2'b11, -1, 0);
        idle(8);
        tests++;
        if (mq.size() != exq.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d want %0d", mq.size(), exq.size());
        end
        for (int i = 0; i < exq.size() && i < mq.size(); i++) begin
            tests++;
            if (mq[i] !== exq[i]) begin
                fails++;
                $display("FAIL b2b_frame%0d: got id%0d d=%0h pe=%0b fe=%0b t=%0d want id%0d d=%0h pe=%0b fe=%0b t=%0d",
                         i, mq[i].id, mq[i].d, mq[i].pe, mq[i].fe, mq[i].c,
                         exq[i].id, exq[i].d, exq[i].pe, exq[i].fe, exq[i].c);
            end
        end
        mq.delete();
        exq.delete();
    endtask

    task automatic test_glitch();
        sel = 0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        tests++;
        if (b0 !== 1'b1) begin
            fails++;
            $display("FAIL glitch_busy_hi: got %0b want 1", b0);
        end
        repeat (6) @(negedge clk);
        tests++;
        if (b0 !== 1'b0) begin
            fails++;
            $display("FAIL glitch_busy_lo: got %0b want 0", b0);
        end
        idle(40);
        tests++;
        if (mq.size() != 0) begin
            fails++;
            $display("FAIL glitch_novalid: got %0d frames want 0", mq.size());
        end
        mq.delete();
    endtask

    task automatic test_parity();
        idle(4);
        send(1, 16, 8, 2, 9'h045, 1'b1, 1, 2'b11, -1, 0);
        send(1, 16, 8, 2, 9'h045, 1'b0, 1, 2'b11, -1, 0);
        for (int i = 0; i < 4; i++)
            send(1, 16, 8, 2, 9'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1, 2'b11, -1, 0);
        idle(4);
        send(2, 16, 8, 1, 9'h045, 1'b0, 1, 2'b11, -1, 0);
        send(2, 16, 8, 1, 9'h045, 1'b1, 1, 2'b11, -1, 0);
        for (int i = 0; i < 4; i++)
            send(2, 16, 8, 1, 9'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1, 2'b11, -1, 0);
        idle(8);
        tests++;
        if (mq.size() != exq.size()) begin
            fails++;
            $display("FAIL par_count: got %0d want %0d", mq.size(), exq.size());
        end
        for (int i = 0; i < exq.size() && i < mq.size(); i++) begin
            tests++;
            if (mq[i] !== exq[i]) begin
                fails++;
                $display("FAIL par_frame%0d: got id%0d d=%0h pe=%0b fe=%0b t=%0d want id%0d d=%0h pe=%0b fe=%0b t=%0d",
                         i, mq[i].id, mq[i].d, mq[i].pe, mq[i].fe, mq[i].c,
                         exq[i].id, exq[i].d, exq[i].pe, exq[i].fe, exq[i].c);
            end
        end
        mq.delete();
        exq.delete();
    endtask

    task automatic test_stop2();
        logic [1:0] sv;
        idle(4);
        send(3, 16, 8, 0, 9'h0A5, 1'b0, 2, 2'b01, -1, 0);
        repeat (48) @(negedge clk);
        tests++;
        if (mq.size() != 1) begin
            fails++;
            $display("FAIL stop2_break: got %0d frames want 1", mq.size());
        end
        idle(32);
        send(3, 16, 8, 0, 9'h03C, 1'b0, 2, 2'b11, -1, 0);
        for (int i = 0; i < 4; i++) begin
            sv = 2'($urandom_range(0, 3));
            send(3, 16, 8, 0, 9'($urandom_range(0, 255)), 1'b0, 2, sv, -1, 0);
            idle(16);
        end
        idle(8);
        tests++;
        if (mq.size() != exq.size()) begin
            fails++;
            $display("FAIL stop2_count: got %0d want %0d", mq.size(), exq.size());
        end
        for (int i = 0; i < exq.size() && i < mq.size(); i++) begin
            tests++;
            if (mq[i] !== exq[i]) begin
                fails++;
                $display("FAIL stop2_frame%0d: got id%0d d=%0h pe=%0b fe=%0b t=%0d want id%0d d=%0h pe=%0b fe=%0b t=%0d",
                         i, mq[i].id, mq[i].d, mq[i].pe, mq[i].fe, mq[i].c,
                         exq[i].id, exq[i].d, exq[i].pe, exq[i].fe, exq[i].c);
            end
        end
        mq.delete();
        exq.delete();
    endtask

    task automatic test_enable();
        idle(4);
        send(0, 16, 8, 0, 9'h03C, 1'b0, 1, 2'b11, 4, 1);
        tests++;
        if (b0 !== 1'b0) begin
            fails++;
            $display("FAIL en_busy: got %0b want 0", b0);
        end
        en = 1'b1;
        tests++;
        if (int'(d0) !== last_d[0]) begin
            fails++;
            $display("FAIL en_hold: got %0h want %0h", d0, last_d[0]);
        end
        idle(16);
        send(0, 16, 8, 0, 9'h081, 1'b0, 1, 2'b11, -1, 0);
        idle(8);
        tests++;
        if (mq.size() != exq.size()) begin
            fails++;
            $display("FAIL en_count: got %0d want %0d", mq.size(), exq.size());
        end
        for (int i = 0; i < exq.size() && i < mq.size(); i++) begin
            tests++;
            if (mq[i] !== exq[i]) begin
                fails++;
                $display("FAIL en_frame%0d: got id%0d d=%0h pe=%0b fe=%0b t=%0d want id%0d d=%0h pe=%0b fe=%0b t=%0d",
                         i, mq[i].id, mq[i].d, mq[i].pe, mq[i].fe, mq[i].c,
                         exq[i].id, exq[i].d, exq[i].pe, exq[i].fe, exq[i].c);
            end
        end
        mq.delete();
        exq.delete();
    endtask

    task automatic test_rst_mid();
        idle(4);
        send(0, 16, 8, 0, 9'($urandom_range(1, 255)) | 9'h001, 1'b0, 1, 2'b11, -1, 0);
        send(0, 16, 8, 0, 9'h07E, 1'b0, 1, 2'b11, 4, 2);
        tests++;
        if ({snap_d, snap_v, snap_pe, snap_fe, snap_b} !== 13'h0000) begin
            fails++;
            $display("FAIL rstmid_outs: got d=%0h v=%0b pe=%0b fe=%0b busy=%0b want all 0",
                     snap_d, snap_v, snap_pe, snap_fe, snap_b);
        end
        rst = 1'b0;
        idle(8);
        send(0, 16, 8, 0, 9'h012, 1'b0, 1, 2'b11, -1, 0);
        idle(8);
        tests++;
        if (mq.size() != exq.size()) begin
            fails++;
            $display("FAIL rstmid_count: got %0d want %0d", mq.size(), exq.size());
        end
        for (int i = 0; i < exq.size() && i < mq.size(); i++) begin
            tests++;
            if (mq[i] !== exq[i]) begin
                fails++;
                $display("FAIL rstmid_frame%0d: got id%0d d=%0h pe=%0b fe=%0b t=%0d want id%0d d=%0h pe=%0b fe=%0b t=%0d",
                         i, mq[i].id, mq[i].d, mq[i].pe, mq[i].fe, mq[i].c,
                         exq[i].id, exq[i].d, exq[i].pe, exq[i].fe, exq[i].c);
            end
        end
        mq.delete();
        exq.delete();
    endtask

    task automatic test_wide();
        idle(4);
        send(4, 1041, 7, 0, 9'h045, 1'b0, 1, 2'b11, -1, 0);
        send(4, 1041, 7, 0, 9'($urandom_range(0, 127)), 1'b0, 1, 2'b11, -1, 0);
        idle(8);
        tests++;
        if (mq.size() != exq.size()) begin
            fails++;
            $display("FAIL wide_count: got %0d want %0d", mq.size(), exq.size());
        end
        for (int i = 0; i < exq.size() && i < mq.size(); i++) begin
            tests++;
            if (mq[i] !== exq[i]) begin
                fails++;
                $display("FAIL wide_frame%0d: got id%0d d=%0h pe=%0b fe=%0b t=%0d want id%0d d=%0h pe=%0b fe=%0b t=%0d",
                         i, mq[i].id, mq[i].d, mq[i].pe, mq[i].fe, mq[i].c,
                         exq[i].id, exq[i].d, exq[i].pe, exq[i].fe, exq[i].c);
            end
        end
        mq.delete();
        exq.delete();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_parity();
        test_stop2();
        test_enable();
        test_rst_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
